// File: rtl/wallace_mul_pkg.sv
// Shared sizing helpers for the pipelined Wallace-tree multiplier.
package wallace_mul_pkg;

  // Number of rows left after `lvls` 3:2 levels starting from n_rows.
  function automatic int unsigned rows_after(int unsigned n_rows, int unsigned lvls);
    int unsigned n;
    n = n_rows;
    for (int unsigned i = 0; i < lvls; i++) begin
      if (n > 2) n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  // CSA levels needed to bring n_rows down to two.
  function automatic int unsigned tree_levels(int unsigned n_rows);
    int unsigned n;
    int unsigned l;
    n = n_rows;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + (n % 3);
      l++;
    end
    return l;
  endfunction

  // Pipeline registers inside the tree: every reg_levels-th level plus the last.
  function automatic int unsigned num_regs(int unsigned levels, int unsigned reg_levels);
    return (levels + reg_levels - 1) / reg_levels;
  endfunction

  // Input register + tree registers + output register.
  function automatic int unsigned latency(int unsigned width, int unsigned reg_levels);
    return 2 + num_regs(tree_levels(width + 2), reg_levels);
  endfunction

  localparam int unsigned LATENCY_W32_R4 = latency(32, 4);

endpackage

// File: rtl/wallace_mul_csa3to2.sv
// Parametrised-width 3:2 carry-save compressor.
module csa3to2 #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  // Bitwise full add; carry shifted up one place and truncated to W bits.
  always_comb begin
    sum   = a ^ b ^ c;
    carry = ((a & b) | (a & c) | (b & c)) << 1;
  end

endmodule

// File: rtl/wallace_mul_pipe.sv
// Pipelined Wallace-tree multiplier, signed/unsigned per beat, global stall.
module wallace_mul_pipe
  import wallace_mul_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_LEVELS = 4,
  parameter int unsigned TAG_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned NR     = WIDTH + 2;
  localparam int unsigned LEVELS = tree_levels(NR);
  localparam logic [PW-1:0] SIGN_ONE = {{(WIDTH-1){1'b0}}, 1'b1, {WIDTH{1'b0}}};

  logic                advance;
  logic                out_valid_d, out_valid_q;
  logic [PW-1:0]       out_p_d, out_p_q;
  logic [TAG_W-1:0]    out_tag_d, out_tag_q;

  logic [WIDTH-1:0]    a_d, a_q, b_d, b_q;
  logic                sgn_d, sgn_q;
  logic [TAG_W-1:0]    itag_d, itag_q;
  logic                ivld_d, ivld_q;

  logic [WIDTH:0]      ext_a, ext_b;
  logic [PW-1:0]       ax, sgn_row;
  logic [PW-1:0]       pp [0:NR-1];
  logic [PW-1:0]       sum_p;

  // Single stall signal shared by every stage; in_ready follows it directly.
  always_comb begin
    advance  = !out_valid_q | out_ready;
    in_ready = advance;
  end

  // Input stage next-state: capture a new beat when the pipe advances.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    sgn_d  = sgn_q;
    itag_d = itag_q;
    ivld_d = ivld_q;
    if (advance) begin
      a_d    = in_a;
      b_d    = in_b;
      sgn_d  = in_signed;
      itag_d = in_tag;
      ivld_d = in_valid;
    end
  end

  // Input stage valid bit, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) ivld_q <= 1'b0;
    else     ivld_q <= ivld_d;
  end

  // Input stage data, no reset needed.
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    sgn_q  <= sgn_d;
    itag_q <= itag_d;
  end

  // Partial products; the sign row is negated as (~row << WIDTH) + (1 << WIDTH).
  always_comb begin
    ext_a   = sgn_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
    ext_b   = sgn_q ? {b_q[WIDTH-1], b_q} : {1'b0, b_q};
    ax      = {{(WIDTH-1){ext_a[WIDTH]}}, ext_a};
    sgn_row = ext_b[WIDTH] ? ax : '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pp[i] = ext_b[i] ? (ax << i) : '0;
    end
    pp[WIDTH]   = (~sgn_row) << WIDTH;
    pp[WIDTH+1] = SIGN_ONE;
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned NIN  = rows_after(NR, l - 1);
    localparam int unsigned NG   = NIN / 3;
    localparam int unsigned NLO  = NIN % 3;
    localparam int unsigned NOUT = 2 * NG + NLO;

    logic [PW-1:0]    src    [0:NIN-1];
    logic [PW-1:0]    nx     [0:NOUT-1];
    logic [PW-1:0]    rows_o [0:NOUT-1];
    logic             src_vld, vld_o;
    logic [TAG_W-1:0] src_tag, tag_o;

    if (l == 1) begin : g_src0
      for (genvar r = 0; r < NIN; r++) begin : g_r
        assign src[r] = pp[r];
      end
      assign src_vld = ivld_q;
      assign src_tag = itag_q;
    end else begin : g_srcn
      for (genvar r = 0; r < NIN; r++) begin : g_r
        assign src[r] = g_lvl[l-1].rows_o[r];
      end
      assign src_vld = g_lvl[l-1].vld_o;
      assign src_tag = g_lvl[l-1].tag_o;
    end

    for (genvar g = 0; g < NG; g++) begin : g_csa
      csa3to2 #(.W(PW)) u_csa (
        .a     (src[3*g]),
        .b     (src[3*g+1]),
        .c     (src[3*g+2]),
        .sum   (nx[2*g]),
        .carry (nx[2*g+1])
      );
    end

    for (genvar p = 0; p < NLO; p++) begin : g_pass
      assign nx[2*NG+p] = src[3*NG+p];
    end

    if ((l % REG_LEVELS == 0) || (l == LEVELS)) begin : g_reg
      logic [PW-1:0]    rows_d [0:NOUT-1];
      logic [PW-1:0]    rows_q [0:NOUT-1];
      logic             vld_d, vld_q;
      logic [TAG_W-1:0] tag_d, tag_q;

      // Tree stage next-state: take the level output on advance, else hold.
      always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        for (int unsigned r = 0; r < NOUT; r++) rows_d[r] = rows_q[r];
        if (advance) begin
          vld_d = src_vld;
          tag_d = src_tag;
          for (int unsigned r = 0; r < NOUT; r++) rows_d[r] = nx[r];
        end
      end

      // Tree stage valid bit, cleared by reset.
      always_ff @(posedge clk) begin
        if (rst) vld_q <= 1'b0;
        else     vld_q <= vld_d;
      end

      // Tree stage data and tag.
      always_ff @(posedge clk) begin
        tag_q <= tag_d;
        for (int unsigned r = 0; r < NOUT; r++) rows_q[r] <= rows_d[r];
      end

      for (genvar r = 0; r < NOUT; r++) begin : g_o
        assign rows_o[r] = rows_q[r];
      end
      assign vld_o = vld_q;
      assign tag_o = tag_q;
    end else begin : g_comb
      for (genvar r = 0; r < NOUT; r++) begin : g_o
        assign rows_o[r] = nx[r];
      end
      assign vld_o = src_vld;
      assign tag_o = src_tag;
    end
  end

  // Final carry-propagate add, carry out of the MSB dropped.
  always_comb begin
    sum_p = g_lvl[LEVELS].rows_o[0] + g_lvl[LEVELS].rows_o[1];
  end

  // Output stage next-state; product/tag only load with a valid beat.
  always_comb begin
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    out_tag_d   = out_tag_q;
    if (advance) begin
      out_valid_d = g_lvl[LEVELS].vld_o;
      if (g_lvl[LEVELS].vld_o) begin
        out_p_d   = sum_p;
        out_tag_d = g_lvl[LEVELS].tag_o;
      end
    end
  end

  // Output stage, fully reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Self-checking bench for wallace_mul_pipe (32-bit/REG_LEVELS=4 and 4-bit/REG_LEVELS=1).
module tb_wallace_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, in_signed;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [63:0] out_p;
  logic [3:0]  out_tag;

  logic        n_in_valid, n_in_ready, n_in_signed;
  logic [3:0]  n_in_a, n_in_b, n_in_tag;
  logic        n_out_valid, n_out_ready;
  logic [7:0]  n_out_p;
  logic [3:0]  n_out_tag;

  int total = 0;
  int bad   = 0;

  wallace_mul_pipe #(.WIDTH(32), .REG_LEVELS(4), .TAG_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag)
  );

  wallace_mul_pipe #(.WIDTH(4), .REG_LEVELS(1), .TAG_W(4)) u_dut_n (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_signed(n_in_signed), .in_a(n_in_a), .in_b(n_in_b), .in_tag(n_in_tag),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_p(n_out_p), .out_tag(n_out_tag)
  );

  // Hand-computed corner products.
  logic        c_s [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] c_a [8] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                           32'h80000000, 32'h00000007, 32'h00000000, 32'h7FFFFFFF};
  logic [31:0] c_b [8] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'hFFFFFFFF,
                           32'h00000002, 32'hFFFFFFFD, 32'h12345678, 32'h7FFFFFFF};
  logic [63:0] c_p [8] = '{64'h0000000000000001, 64'h4000000000000000,
                           64'hFFFFFFFF80000000, 64'hFFFFFFFE00000001,
                           64'h0000000100000000, 64'hFFFFFFFFFFFFFFEB,
                           64'h0000000000000000, 64'h3FFFFFFF00000001};

  function automatic logic [63:0] ref_mul32(input logic s, input logic [31:0] a,
                                            input logic [31:0] b);
    longint av, bv;
    av = s ? longint'(signed'(a)) : longint'({32'h0, a});
    bv = s ? longint'(signed'(b)) : longint'({32'h0, b});
    return 64'(av * bv);
  endfunction

  function automatic logic [7:0] ref_mul4(input logic s, input logic [3:0] a,
                                          input logic [3:0] b);
    int av, bv;
    av = (s && a[3]) ? int'(a) - 16 : int'(a);
    bv = (s && b[3]) ? int'(b) - 16 : int'(b);
    return 8'(av * bv);
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    total++; if (out_p !== 64'h0) begin bad++; $display("FAIL reset_out_p: got %h exp 0", out_p); end
    total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL reset_out_tag: got %h exp 0", out_tag); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    total++; if (n_out_valid !== 1'b0) begin bad++; $display("FAIL reset_n_out_valid: got %b exp 0", n_out_valid); end
  endtask

  task automatic test_corners;
    int lat;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_signed = c_s[i]; in_a = c_a[i]; in_b = c_b[i];
      in_tag = 4'(i); out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
      total++; if (lat != 4) begin bad++; $display("FAIL corner%0d_latency: got %0d exp 4", i, lat); end
      total++; if (out_p !== c_p[i]) begin bad++; $display("FAIL corner%0d_p: got %h exp %h", i, out_p, c_p[i]); end
      total++; if (out_tag !== 4'(i)) begin bad++; $display("FAIL corner%0d_tag: got %h exp %h", i, out_tag, 4'(i)); end
    end
  endtask

  task automatic test_stream(input int n, input bit bp);
    logic [63:0] exp_p [$];
    logic [3:0]  exp_t [$];
    logic [63:0] ep, held_p;
    logic [3:0]  et, held_t;
    bit held, fresh;
    int sent, got, first_acc, first_out, last_out;
    sent = 0; got = 0; first_acc = -1; first_out = -1; last_out = 0;
    held = 1'b0; fresh = 1'b1; held_p = '0; held_t = '0;
    for (int c = 0; c < n * 4 + 50 && got < n; c++) begin
      @(posedge clk); #1;
      if (sent >= n) in_valid = 1'b0;
      else if (fresh) begin
        in_valid = 1'b1; in_signed = 1'($urandom_range(0, 1));
        in_a = $urandom; in_b = $urandom; in_tag = 4'(sent); fresh = 1'b0;
      end
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (held) begin
        total++;
        if (out_valid !== 1'b1 || out_p !== held_p || out_tag !== held_t) begin
          bad++; $display("FAIL stall_hold: got v=%b p=%h t=%h exp v=1 p=%h t=%h", out_valid, out_p, out_tag, held_p, held_t);
        end
      end
      if (out_valid === 1'b1) begin
        total++;
        if (in_ready !== out_ready) begin bad++; $display("FAIL ready_follow: got in_ready=%b exp %b", in_ready, out_ready); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        total++;
        if (exp_p.size() == 0) begin bad++; $display("FAIL stream_extra: got p=%h exp no result", out_p); end
        else begin
          ep = exp_p.pop_front(); et = exp_t.pop_front();
          if (out_p !== ep || out_tag !== et) begin
            bad++; $display("FAIL stream_result: got p=%h t=%h exp p=%h t=%h", out_p, out_tag, ep, et);
          end
        end
        got++;
        if (first_out < 0) first_out = c;
        last_out = c;
      end
      held = (out_valid === 1'b1) && !out_ready;
      held_p = out_p; held_t = out_tag;
      if (in_valid && in_ready === 1'b1) begin
        exp_p.push_back(ref_mul32(in_signed, in_a, in_b));
        exp_t.push_back(in_tag);
        sent++; fresh = 1'b1;
        if (first_acc < 0) first_acc = c;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (got != n) begin bad++; $display("FAIL stream_count: got %0d exp %0d", got, n); end
    if (!bp) begin
      total++; if (first_out - first_acc != 4) begin bad++; $display("FAIL stream_latency: got %0d exp 4", first_out - first_acc); end
      total++; if (last_out - first_out != n - 1) begin bad++; $display("FAIL stream_gaps: got span %0d exp %0d", last_out - first_out, n - 1); end
    end
  endtask

  task automatic test_back_to_back;
    test_stream(1000, 1'b0);
  endtask

  task automatic test_backpressure;
    test_stream(300, 1'b1);
  endtask

  task automatic test_reset_mid;
    int stale, lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_signed = 1'b0; in_a = 32'(i + 1); in_b = 32'h10; in_tag = 4'(i);
    end
    @(posedge clk); #1;
    in_tag = 4'h3; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b exp 0", out_valid); end
    total++; if (out_p !== 64'h0) begin bad++; $display("FAIL rstmid_p: got %h exp 0", out_p); end
    stale = 0;
    repeat (10) begin @(negedge clk); if (out_valid !== 1'b0) stale++; end
    total++; if (stale != 0) begin bad++; $display("FAIL rstmid_stale: got %0d stale cycles exp 0", stale); end
    @(posedge clk); #1;
    in_valid = 1'b1; in_signed = 1'b0; in_a = 32'd5; in_b = 32'd6; in_tag = 4'h9;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (out_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    total++; if (lat != 4) begin bad++; $display("FAIL rstmid_latency: got %0d exp 4", lat); end
    total++; if (out_p !== 64'd30 || out_tag !== 4'h9) begin
      bad++; $display("FAIL rstmid_result: got p=%h t=%h exp p=%h t=9", out_p, out_tag, 64'd30);
    end
    @(posedge clk);
  endtask

  task automatic test_narrow_exhaustive;
    logic [7:0] exp_p [$];
    logic [3:0] exp_t [$];
    logic [7:0] ep;
    logic [3:0] et;
    int sent, got, first_acc, first_out, last_out;
    sent = 0; got = 0; first_acc = -1; first_out = -1; last_out = 0;
    n_out_ready = 1'b1;
    for (int c = 0; c < 700 && got < 512; c++) begin
      @(posedge clk); #1;
      if (sent < 512) begin
        n_in_valid = 1'b1; n_in_signed = sent[8];
        n_in_a = sent[7:4]; n_in_b = sent[3:0]; n_in_tag = 4'(sent);
      end else n_in_valid = 1'b0;
      @(negedge clk);
      if (n_out_valid === 1'b1) begin
        total++;
        if (exp_p.size() == 0) begin bad++; $display("FAIL narrow_extra: got p=%h exp no result", n_out_p); end
        else begin
          ep = exp_p.pop_front(); et = exp_t.pop_front();
          if (n_out_p !== ep || n_out_tag !== et) begin
            bad++; $display("FAIL narrow_result: got p=%h t=%h exp p=%h t=%h", n_out_p, n_out_tag, ep, et);
          end
        end
        got++;
        if (first_out < 0) first_out = c;
        last_out = c;
      end
      if (n_in_valid && n_in_ready === 1'b1) begin
        exp_p.push_back(ref_mul4(n_in_signed, n_in_a, n_in_b));
        exp_t.push_back(n_in_tag);
        sent++;
        if (first_acc < 0) first_acc = c;
      end
    end
    n_in_valid = 1'b0;
    total++; if (got != 512) begin bad++; $display("FAIL narrow_count: got %0d exp 512", got); end
    total++; if (first_out - first_acc != 5) begin bad++; $display("FAIL narrow_latency: got %0d exp 5", first_out - first_acc); end
    total++; if (last_out - first_out != 511) begin bad++; $display("FAIL narrow_gaps: got span %0d exp 511", last_out - first_out); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;
    n_in_valid = 1'b0; n_in_signed = 1'b0; n_in_a = '0; n_in_b = '0; n_in_tag = '0;
    n_out_ready = 1'b1;
    test_reset;
    test_corners;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_narrow_exhaustive;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wallace_mul_pipe.md
# wallace_mul_pipe

Pipelined, parametrised Wallace-tree multiplier that computes the full 2·WIDTH-bit product of two WIDTH-bit operands at a throughput of one product per clock. Each transaction selects signed or unsigned operation. The block replaces the combinational 32×32 signed tree in the datapath. It sits between an operand-issue stage and a result consumer, with valid/ready handshakes on both sides and full back-pressure support. A user tag travels alongside each product so the consumer can match results to requests.

## Interface
- WIDTH, 32: operand width in bits, ≥4.
- REG_LEVELS, 4: CSA levels between pipeline registers inside the tree, ≥1.
- TAG_W, 4: width of the sideband tag, ≥1.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_signed  in  1  1: treat A and B as two's complement; 0: treat them as unsigned.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- out_p  out  2·WIDTH  product.
- out_tag  out  TAG_W  tag of the product.

## Operation
- **Operand extension:** each operand is extended to WIDTH+1 bits. In signed mode the MSB is replicated; in unsigned mode a 0 is prepended.
- **Partial products:** WIDTH+1 partial products are formed. Row i = ext_A << i when ext_B[i] = 1, otherwise 0, computed at 2·WIDTH bits.
- **Sign row:** row WIDTH is subtracted rather than added, because it carries the weight of the sign bit. It enters the tree as ~row + 1. The +1 is injected as an extra 1-bit operand at bit WIDTH.
- **Reduction:** a 3:2 carry-save tree reduces the rows to two, level by level. At each level, floor(n/3) groups are compressed and the n mod 3 leftover rows pass through unchanged.
  - LEVELS is the resulting level count (8 for WIDTH=32).
- **Final add:** a 2·WIDTH-bit carry-propagate adder sums the two remaining rows.
- **Width rule:** the result is truncated to 2·WIDTH bits. Carries out of the MSB are discarded. This truncation is what makes the exact product come out in both modes.
- **Pipeline registers:**
  - Input register, which captures operands, mode and tag.
  - One register after every REG_LEVELS-th CSA level, plus one after the last level if it is not already registered.
  - Output register after the CPA.
- **Stage valids:** each stage has a valid bit. The tag and a stage-valid bit ride along with the data.
- **Global stall:** advance = !out_valid | out_ready. When advance is low, every register holds its value; no bubble collapsing.
- **Input acceptance:** in_ready = advance. A beat is accepted when in_valid & in_ready.
- **Reset:** on rst, all stage-valid bits clear.
  - out_valid = 0, out_p = 0, out_tag = 0.
  - Data registers other than the output need not reset.
  - Reset mid-operation discards every in-flight product, and none appears afterwards.

## Timing
- LATENCY = 2 + ceil(LEVELS/REG_LEVELS) cycles from acceptance to out_valid, with out_ready held high. For WIDTH=32, REG_LEVELS=4: LATENCY = 4.
- **Throughput:** one result per cycle with no bubbles while out_ready = 1.
- **Holding under back-pressure:** while out_valid & !out_ready, out_p and out_tag are held stable, and out_valid stays 1.
- **Readiness during a stall:** in_ready is 0 in the same cycle, so it depends combinationally on out_ready. The upstream stage must tolerate this.
- **Simultaneous events:** an output handshake and an input acceptance in the same cycle both complete. Occupancy is unchanged.
- **Order:** results leave in acceptance order. No reordering, no drops, no duplication.
- **Reset priority:** rst has priority over any handshake in the same cycle.

## Structure
- Package wallace_mul_pkg holds:
  - function tree_levels(n_rows), computing the level count for a given row count;
  - function num_regs(levels, reg_levels);
  - localparam helpers for LATENCY.
- Sub-module csa3to2: a parametrised-width 3:2 compressor.
  - sum = a^b^c;
  - carry = maj(a,b,c) << 1, truncated to width.
- Each tree level is a generate loop of csa3to2 instances, plus pass-through rows.
- The stage register is a generate-if on (level % REG_LEVELS == 0).

## Test plan
- **Signed corners (WIDTH=32):**
  - signed −1 × −1 → 0x0000000000000001;
  - 0x80000000 × 0x80000000 → 0x4000000000000000;
  - 0x80000000 × 1 → 0xFFFFFFFF80000000.
- **Unsigned corners:**
  - 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE00000001;
  - 0x80000000 × 2 → 0x0000000100000000.
- **Streaming:** 1000 random back-to-back beats with mixed mode and incrementing tags, out_ready = 1. Each result equals the reference model. Tags arrive in order. The first out_valid appears exactly 4 cycles after the first accept. There are no gaps.
- **Back-pressure:**
  - random out_ready (50%) under a continuous input stream;
  - required: no loss or duplication, out_p stable while stalled, in_ready == out_ready whenever out_valid = 1.
- **Reset mid-stream:** assert rst for 1 cycle with 3 products in flight. Required:
  - next cycle, out_valid = 0 and out_p = 0;
  - no stale result ever emerges;
  - the next accepted beat appears LATENCY cycles later.
- **Parameter sweep:** WIDTH ∈ {4, 8, 16}, REG_LEVELS ∈ {1, 2, 8}. Run an exhaustive sweep at WIDTH=4 in both modes. The measured latency must match the package LATENCY.
